// File: rtl/s526_bist_pkg.sv
// Shared types, tap constants and step functions for the s526 BIST sequencer.
// Both the controller and its MISR use the step functions.
package s526_bist_pkg;

  localparam int unsigned SIG_W = 16;

  // Tap masks: LFSR x^16+x^14+x^13+x^11+1 (bits 15,13,12,10); MISR bits 15,14,12,3.
  localparam logic [SIG_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [SIG_W-1:0] MISR_TAPS = 16'hD008;

  typedef enum logic [2:0] {
    StIdle,
    StFlush,
    StRun,
    StDrain,
    StDone
  } state_e;

  function automatic logic [SIG_W-1:0] lfsr_step(input logic [SIG_W-1:0] l);
    return {l[SIG_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] m,
                                                 input logic [SIG_W-1:0] d);
    return {m[SIG_W-2:0], ^(m & MISR_TAPS)} ^ d;
  endfunction

endpackage

// File: rtl/bist_misr16.sv
// 16-bit multiple-input signature register compacting the DUT response stream.
// init reloads the seed at the start of every test; en gates each capture.
module bist_misr16
  import s526_bist_pkg::*;
#(
  parameter logic [SIG_W-1:0] MISR_SEED = 16'h0000
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             init,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q;

  always_ff @(posedge CLOCK) begin
    if (RESET || init) begin
      sig_q <= MISR_SEED;
    end else if (en) begin
      sig_q <= misr_step(sig_q, din);
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/s526_bist_ctrl.sv
// BIST sequencer for s526: flush vector, LFSR patterns, MISR compaction and
// a golden-signature compare, driven by a START/DONE handshake.
module s526_bist_ctrl
  import s526_bist_pkg::*;
#(
  parameter int unsigned      N_IN      = 3,
  parameter int unsigned      N_OUT     = 6,
  parameter int unsigned      PAT_CNT   = 256,
  parameter int unsigned      FLUSH_CYC = 8,
  parameter logic [N_IN-1:0]  FLUSH_VEC = 3'b001,
  parameter logic [SIG_W-1:0] LFSR_SEED = 16'hACE1,
  parameter logic [SIG_W-1:0] MISR_SEED = 16'h0000,
  localparam int unsigned     CNT_W     = $clog2(PAT_CNT + 1)
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             START,
  input  logic             ABORT,
  input  logic [SIG_W-1:0] GOLDEN_SIG,
  input  logic [N_OUT-1:0] DUT_OUT,
  output logic [N_IN-1:0]  DUT_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [SIG_W-1:0] SIGNATURE,
  output logic [CNT_W-1:0] PAT_IDX
);

  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] PAT_LAST   = CNT_W'(PAT_CNT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIG_W-1:0] lfsr_q, lfsr_d;
  logic [N_IN-1:0]  dut_in_q, dut_in_d;
  logic             cap_en_q;
  logic             pass_q, pass_d;
  logic             busy;
  logic             misr_init;
  logic             misr_en;
  logic [SIG_W-1:0] misr_din;
  logic [SIG_W-1:0] sig;

  assign busy     = (state_q == StFlush) || (state_q == StRun) || (state_q == StDrain);
  assign misr_din = SIG_W'(DUT_OUT);
  // cap_en_q lingers one cycle after an abort from RUN; the state gate keeps SIGNATURE frozen.
  assign misr_en  = cap_en_q && !ABORT && ((state_q == StRun) || (state_q == StDrain));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    dut_in_d  = dut_in_q;
    pass_d    = pass_q;
    misr_init = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (START) begin
          state_d   = StFlush;
          cnt_d     = '0;
          lfsr_d    = LFSR_SEED;
          dut_in_d  = FLUSH_VEC;
          pass_d    = 1'b0;
          misr_init = 1'b1;
        end
      end
      StFlush: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d  = StRun;
          cnt_d    = '0;
          dut_in_d = lfsr_q[N_IN-1:0];
          lfsr_d   = lfsr_step(lfsr_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (cnt_q == PAT_LAST) begin
          state_d  = StDrain;
          cnt_d    = '0;
          dut_in_d = FLUSH_VEC;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          dut_in_d = lfsr_q[N_IN-1:0];
          lfsr_d   = lfsr_step(lfsr_q);
        end
      end
      StDrain: begin
        // The last capture lands on this same edge, so compare the post-capture value.
        state_d = StDone;
        pass_d  = (misr_step(sig, misr_din) == GOLDEN_SIG);
      end
      default: state_d = StIdle;
    endcase
    if (busy && ABORT) begin
      state_d  = StIdle;
      cnt_d    = '0;
      dut_in_d = FLUSH_VEC;
      pass_d   = 1'b0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      dut_in_q <= FLUSH_VEC;
      cap_en_q <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      dut_in_q <= dut_in_d;
      cap_en_q <= (state_q == StRun);
      pass_q   <= pass_d;
    end
  end

  bist_misr16 #(
    .MISR_SEED (MISR_SEED)
  ) u_misr (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .init  (misr_init),
    .en    (misr_en),
    .din   (misr_din),
    .sig   (sig)
  );

  assign DUT_IN    = dut_in_q;
  assign BUSY      = busy;
  assign DONE      = (state_q == StDone);
  assign PASS      = pass_q && (state_q == StDone);
  assign SIGNATURE = sig;
  assign PAT_IDX   = (state_q == StRun) ? cnt_q : '0;

endmodule

// File: tb/tb_s526_bist_ctrl.sv
// Bench for s526_bist_ctrl: a registered stand-in DUT plus a pattern/signature
// model built from the LFSR and MISR polynomials, checked every cycle of each test.
module tb_s526_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] golden;
  logic [5:0]  dut_out, dut_r, fault_mask;
  logic [2:0]  dut_in;
  logic        busy, done, pass;
  logic [15:0] signature;
  logic [8:0]  pat_idx;

  int nvec = 0;
  int nerr = 0;
  int cur_e = 0;

  logic [2:0]  pats[256];
  logic [15:0] sigs[257];
  logic [15:0] clean_sig;

  always #5 clk = ~clk;

  s526_bist_ctrl dut (
    .CLOCK      (clk),
    .RESET      (rst),
    .START      (start),
    .ABORT      (abort),
    .GOLDEN_SIG (golden),
    .DUT_OUT    (dut_out),
    .DUT_IN     (dut_in),
    .BUSY       (busy),
    .DONE       (done),
    .PASS       (pass),
    .SIGNATURE  (signature),
    .PAT_IDX    (pat_idx)
  );

  // Stand-in for the netlist: outputs are flop Q of a fixed function of the inputs.
  function automatic logic [5:0] resp(input logic [2:0] x);
    return {x, x[0] ^ x[1], x[1] & x[2], ~x[2]};
  endfunction

  always @(posedge clk) dut_r <= resp(dut_in);
  assign dut_out = dut_r & ~fault_mask;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [15:0] misr_next(input logic [15:0] m, input logic [5:0] d);
    return {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3]} ^ {10'b0, d};
  endfunction

  // pats[k]: pattern k; sigs[n]: signature after n captures (capture n-1 sees pattern n-1).
  task automatic build_model(input logic [5:0] fm);
    logic [15:0] l;
    logic [15:0] m;
    l = 16'hACE1;
    m = 16'h0000;
    sigs[0] = m;
    for (int k = 0; k < 256; k++) begin
      pats[k] = l[2:0];
      l = lfsr_next(l);
      m = misr_next(m, resp(pats[k]) & ~fm);
      sigs[k+1] = m;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cur_e, act, exp);
    end
  endtask

  task automatic check_reset();
    cmp("rst_busy", {31'b0, busy}, 0);
    cmp("rst_done", {31'b0, done}, 0);
    cmp("rst_pass", {31'b0, pass}, 0);
    cmp("rst_sig", {16'b0, signature}, 32'h0000);
    cmp("rst_dut_in", {29'b0, dut_in}, 32'h1);
    cmp("rst_pat_idx", {23'b0, pat_idx}, 0);
  endtask

  // e counts edges after the START-sampling edge: 0..7 flush, 8..263 run, 264 drain, 265 done.
  task automatic run_test(input logic [15:0] gold, input int abort_k, input int start_k,
                          input int reset_k, input bit pins);
    int k;
    golden = gold;
    @(negedge clk);
    start = 1'b1;
    for (int e = 0; e <= 265; e++) begin
      @(negedge clk);
      start = 1'b0;
      cur_e = e;
      if (e <= 264) begin
        cmp("busy", {31'b0, busy}, 1);
        cmp("done_low", {31'b0, done}, 0);
        cmp("pass_low", {31'b0, pass}, 0);
      end else begin
        cmp("done_at_265", {31'b0, done}, 1);
        cmp("busy_end", {31'b0, busy}, 0);
        cmp("pass", {31'b0, pass}, {31'b0, sigs[256] == gold});
        cmp("dut_in_done", {29'b0, dut_in}, 32'h1);
      end
      if (e < 8) begin
        cmp("flush_dut_in", {29'b0, dut_in}, 32'h1);
      end else if (e <= 263) begin
        cmp("run_dut_in", {29'b0, dut_in}, {29'b0, pats[e-8]});
        cmp("pat_idx", {23'b0, pat_idx}, e - 8);
      end
      cmp("signature", {16'b0, signature}, {16'b0, sigs[(e > 9) ? e - 9 : 0]});
      if (pins) begin
        if (e == 8)  cmp("pin_pat0", {29'b0, dut_in}, 32'h1);
        if (e == 9)  cmp("pin_pat1", {29'b0, dut_in}, 32'h3);
        if (e == 10) cmp("pin_pat2", {29'b0, dut_in}, 32'h7);
        if (e == 10) cmp("pin_sig1", {16'b0, signature}, 32'h000D);
        if (e == 11) cmp("pin_sig2", {16'b0, signature}, 32'h0002);
      end
      if (e >= 8 && e <= 263) begin
        k = e - 8;
        if (k == abort_k) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          cmp("abort_busy", {31'b0, busy}, 0);
          cmp("abort_done", {31'b0, done}, 0);
          cmp("abort_pass", {31'b0, pass}, 0);
          cmp("abort_dut_in", {29'b0, dut_in}, 32'h1);
          cmp("abort_sig", {16'b0, signature}, {16'b0, sigs[e-9]});
          return;
        end
        if (k == start_k) start = 1'b1;
        if (k == reset_k) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          check_reset();
          return;
        end
      end
    end
    repeat (3) begin
      @(negedge clk);
      cmp("hold_done", {31'b0, done}, 1);
      cmp("hold_sig", {16'b0, signature}, {16'b0, sigs[256]});
      cmp("hold_pass", {31'b0, pass}, {31'b0, sigs[256] == gold});
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    golden = 16'h0000;
    fault_mask = 6'b0;
    repeat (2) @(negedge clk);
    check_reset();
    rst = 1'b0;

    build_model(6'b0);
    clean_sig = sigs[256];

    // Matching golden, then a one-bit-off golden started from DONE.
    run_test(clean_sig, -1, -1, -1, 1'b1);
    cmp("golden_pass", {31'b0, pass}, 1);
    run_test(clean_sig ^ 16'h0001, -1, -1, -1, 1'b1);
    cmp("golden_miss_pass", {31'b0, pass}, 0);
    cmp("golden_miss_sig", {16'b0, signature}, {16'b0, clean_sig});

    // DUT_OUT[3] stuck-at-0 for the whole run.
    fault_mask = 6'b001000;
    build_model(fault_mask);
    run_test(clean_sig, -1, -1, -1, 1'b0);
    cmp("fault_pass", {31'b0, pass}, 0);
    cmp("fault_sig_differs", {31'b0, signature != clean_sig}, 1);
    fault_mask = 6'b0;
    build_model(6'b0);

    // Abort at pattern 10, then a clean rerun.
    run_test(clean_sig, 10, -1, -1, 1'b1);
    run_test(clean_sig, -1, -1, -1, 1'b1);
    cmp("rerun_sig", {16'b0, signature}, {16'b0, clean_sig});

    // START while busy is ignored; then restart from DONE and reset mid-run.
    run_test(clean_sig, -1, 50, -1, 1'b1);
    run_test(clean_sig, -1, -1, 100, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
